// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite data-phase response multiplexor.
// Captures the decoder's address-phase select when a transfer is accepted.
// Routes the owning slave's HRDATA/HREADYOUT/HRESP back to the master.
// Hosts the default slave, which answers unmapped active transfers with a
// two-cycle ERROR response.
// Handshake: a transfer is accepted on any rising edge where o_hready==1.
// While o_hready==0 the data-phase owner and every address-phase input are
// ignored and held off until the owning slave drives HREADYOUT high.
module ahb_slave_mux #(
   parameter int            DW        = 32,
   parameter logic [DW-1:0] DEF_RDATA = '0
) (
   input  logic          i_hclk,
   input  logic          i_hresetn,
   input  logic          i_hsel_rom,
   input  logic          i_hsel_ram,
   input  logic          i_hsel_bridge,
   input  logic          i_hsel_def,
   input  logic [1:0]    i_htrans,
   input  logic [DW-1:0] i_hrdata_rom,
   input  logic [DW-1:0] i_hrdata_ram,
   input  logic [DW-1:0] i_hrdata_bridge,
   input  logic          i_hreadyout_rom,
   input  logic          i_hreadyout_ram,
   input  logic          i_hreadyout_bridge,
   input  logic          i_hresp_rom,
   input  logic          i_hresp_ram,
   input  logic          i_hresp_bridge,
   output logic [DW-1:0] o_hrdata,
   output logic          o_hready,
   output logic          o_hresp,
   output logic [3:0]    o_dbg_dsel,
   output logic [1:0]    o_dbg_state
);

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_ERR1 = 2'd1,
      D_ERR2 = 2'd2
   } def_state_e;

   // One-hot select bit positions {def,bridge,ram,rom}
   localparam int S_ROM    = 0;
   localparam int S_RAM    = 1;
   localparam int S_BRIDGE = 2;
   localparam int S_DEF    = 3;

   logic [3:0]  asel;
   logic [3:0]  dsel_d;
   logic [3:0]  dsel_q;
   def_state_e  def_state_q;
   logic        def_hready_q;
   logic        def_hresp_q;
   logic        act;

   // HTRANS[0] only separates BUSY from IDLE and NONSEQ from SEQ; neither
   // distinction matters here, only whether the transfer is active.
   logic        unused_htrans0;
   assign unused_htrans0 = i_htrans[0];

   // Priority-encode the decoder selects; a decoder fault with several
   // selects resolves silently by priority, and no select means default.
   always_comb begin
      asel = 4'b0000;
      if (i_hsel_rom)         asel[S_ROM]    = 1'b1;
      else if (i_hsel_ram)    asel[S_RAM]    = 1'b1;
      else if (i_hsel_bridge) asel[S_BRIDGE] = 1'b1;
      else                    asel[S_DEF]    = 1'b1;
   end

   // Next data-phase owner: take the new select only when the bus advances.
   always_comb begin
      dsel_d = dsel_q;
      if (o_hready) dsel_d = asel;
   end

   // Data-phase select register; reset hands the bus to the default slave.
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) dsel_q <= 4'b1000;
      else            dsel_q <= dsel_d;
   end

   // An active transfer to unmapped space is being accepted this cycle.
   assign act = o_hready & i_htrans[1] & asel[S_DEF];

   // Default slave FSM with registered HREADY/HRESP matching each state.
   always_ff @(posedge i_hclk) begin
      if (!i_hresetn) begin
         def_state_q  <= D_IDLE;
         def_hready_q <= 1'b1;
         def_hresp_q  <= 1'b0;
      end else begin
         case (def_state_q)
            D_IDLE: begin
               if (act) begin
                  def_state_q  <= D_ERR1;
                  def_hready_q <= 1'b0;
                  def_hresp_q  <= 1'b1;
               end else begin
                  def_state_q  <= D_IDLE;
                  def_hready_q <= 1'b1;
                  def_hresp_q  <= 1'b0;
               end
            end
            D_ERR1: begin
               // Second error cycle always follows; HRESP stays ERROR.
               def_state_q  <= D_ERR2;
               def_hready_q <= 1'b1;
               def_hresp_q  <= 1'b1;
            end
            D_ERR2: begin
               // A new unmapped access here chains straight into ERR1;
               // a master cancel (IDLE) simply falls back to D_IDLE.
               if (act) begin
                  def_state_q  <= D_ERR1;
                  def_hready_q <= 1'b0;
                  def_hresp_q  <= 1'b1;
               end else begin
                  def_state_q  <= D_IDLE;
                  def_hready_q <= 1'b1;
                  def_hresp_q  <= 1'b0;
               end
            end
            default: begin
               def_state_q  <= D_IDLE;
               def_hready_q <= 1'b1;
               def_hresp_q  <= 1'b0;
            end
         endcase
      end
   end

   // Response mux on the registered owner; the default slave is the
   // fall-through so outputs never depend on unselected slave inputs.
   always_comb begin
      o_hrdata = DEF_RDATA;
      o_hready = def_hready_q;
      o_hresp  = def_hresp_q;
      if (dsel_q[S_ROM]) begin
         o_hrdata = i_hrdata_rom;
         o_hready = i_hreadyout_rom;
         o_hresp  = i_hresp_rom;
      end else if (dsel_q[S_RAM]) begin
         o_hrdata = i_hrdata_ram;
         o_hready = i_hreadyout_ram;
         o_hresp  = i_hresp_ram;
      end else if (dsel_q[S_BRIDGE]) begin
         o_hrdata = i_hrdata_bridge;
         o_hready = i_hreadyout_bridge;
         o_hresp  = i_hresp_bridge;
      end
   end

   assign o_dbg_dsel  = dsel_q;
   assign o_dbg_state = def_state_q;

endmodule
